freeze_cart_ctrl: RTL and testbench

- Parametrised next-generation freeze-cartridge controller.
- Sits beside the chipset address decoder and handles several freeze sources.
- Forces an NMI (level-7) vector override so the CPU enters a monitor ROM in the cart RAM bank.
- Provides a custom-register shadow mirror that is frozen while the monitor runs, plus a status/exit register block, so the monitor can read pre-freeze chip state and return cleanly.

---
 rtl/freeze_cart_pkg.sv | 24 ++
 rtl/reg_mirror_ram.sv | 29 ++
 rtl/freeze_cart_ctrl.sv | 173 +++++++++++++++++
 tb/tb_freeze_cart_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freeze_cart_pkg.sv
// Shared types and constants for the freeze-cartridge controller.
// Holds the FSM encoding, status/exit offsets and the ack-cycle address.
package freeze_cart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PEND   = 3'd1,
        ST_OVR    = 3'd2,
        ST_ACTIVE = 3'd3
    } fc_state_e;

    localparam logic [11:0] STATUS_OFS = 12'h200;
    localparam logic [11:0] EXIT_OFS   = 12'h202;

    localparam logic [23:1] ACK_ADR = 23'h7F_FFFF;

    function automatic logic [15:0] status_word(
        input logic [7:0] src,
        input fc_state_e  st
    );
        return {src, 5'b0_0000, st};
    endfunction

endpackage

// File: rtl/reg_mirror_ram.sv
// Custom-register shadow RAM: one write port, one registered read port.
// The read register runs every clock so reads never wait on the 7 MHz enable.
module reg_mirror_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [0:DEPTH-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/freeze_cart_ctrl.sv
// Freeze-cartridge controller: NMI vector override into the monitor,
// frozen register mirror and status/exit block on the OR data bus.
module freeze_cart_ctrl
    import freeze_cart_pkg::*;
#(
    parameter logic [4:0]  CART_BASE = 5'b10100,
    parameter logic [11:0] MIR_BASE  = 12'hA9F,
    parameter logic [31:0] NMI_OFS   = 32'h0000_007C,
    parameter logic [31:0] ENTRY     = 32'h00A1_000C,
    parameter int          MIR_AW    = 8,
    parameter int          NSRC      = 2
) (
    input  logic              clk,
    input  logic              cpu_rst,
    input  logic              clk7_en,
    input  logic [23:1]       cpu_address_in,
    input  logic              _cpu_as,
    input  logic              cpu_rd,
    input  logic              cpu_hwr,
    input  logic              cpu_lwr,
    input  logic [31:0]       cpu_vbr,
    input  logic              dbr,
    input  logic              ovl,
    input  logic [MIR_AW-1:0] reg_address_in,
    input  logic [15:0]       reg_data_in,
    input  logic              reg_wr,
    input  logic [NSRC-1:0]   freeze,
    output logic [15:0]       cart_data_out,
    output logic              int7,
    output logic              sel_cart,
    output logic              ovr,
    output logic              frozen
);

    localparam logic [11:0] MIR_WORDS = 12'(1 << MIR_AW);

    fc_state_e         state_q;
    fc_state_e         state_d;
    logic [NSRC-1:0]   src_q;
    logic [NSRC-1:0]   src_d;
    logic [NSRC-1:0]   freeze_q;
    logic [NSRC-1:0]   rise;
    logic              int7_q;
    logic              frozen_q;
    logic [23:2]       nmi_adr_q;
    logic [31:0]       nmi_sum;
    logic              unused_ok;

    logic              mir_page;
    logic              sel_mir;
    logic [11:0]       page_ofs;
    logic              mir_range;
    logic              stat_hit;
    logic              exit_wr;
    logic              ack;
    logic              cart_rd;
    logic [7:0]        src8;
    logic [15:0]       mir_rdata;
    logic [15:0]       vec_data;
    logic [15:0]       mir_data;
    logic [15:0]       stat_data;

    // Address decode
    assign sel_cart = ~dbr & (cpu_address_in[23:19] == CART_BASE);
    assign mir_page = ~dbr & (cpu_address_in[23:12] == MIR_BASE);
    assign sel_mir  = mir_page & cpu_rd;
    assign page_ofs = {cpu_address_in[11:1], 1'b0};

    assign mir_range = ({1'b0, cpu_address_in[11:1]} < MIR_WORDS)
                     & (page_ofs < STATUS_OFS);
    assign stat_hit  = (page_ofs == STATUS_OFS);
    assign exit_wr   = mir_page & (page_ofs == EXIT_OFS)
                     & (cpu_hwr | cpu_lwr);

    assign ack     = (cpu_address_in == ACK_ADR) & ~_cpu_as & cpu_rd;
    assign cart_rd = sel_cart & cpu_rd;
    assign rise    = freeze & ~freeze_q;

    // Only the compared window of the vector address is kept
    assign nmi_sum   = cpu_vbr + NMI_OFS;
    assign unused_ok = &{1'b0, nmi_sum[31:24], nmi_sum[1:0]};

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            nmi_adr_q <= nmi_sum[23:2];
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    state_d = ST_PEND;
                    src_d   = rise;
                end
            end
            ST_PEND: begin
                src_d = src_q | rise;
                if (ack) begin
                    state_d = ST_OVR;
                end
            end
            ST_OVR: begin
                src_d = src_q | rise;
                if (cart_rd) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                src_d = src_q | rise;
                if (exit_wr) begin
                    state_d = ST_IDLE;
                    src_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                src_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (cpu_rst) begin
                state_q  <= ST_IDLE;
                src_q    <= '0;
                freeze_q <= '0;
                int7_q   <= 1'b0;
                frozen_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                src_q    <= src_d;
                freeze_q <= freeze;
                int7_q   <= (state_d == ST_PEND);
                frozen_q <= (state_d == ST_ACTIVE);
            end
        end
    end

    reg_mirror_ram #(
        .AW (MIR_AW),
        .DW (16)
    ) u_mirror (
        .clk     (clk),
        .we_i    (clk7_en & reg_wr & ~frozen_q),
        .waddr_i (reg_address_in),
        .wdata_i (reg_data_in),
        .raddr_i (cpu_address_in[MIR_AW:1]),
        .rdata_o (mir_rdata)
    );

    assign ovr = (state_q == ST_OVR) & ~dbr & ~ovl & cpu_rd
               & (cpu_address_in[23:2] == nmi_adr_q);

    always_comb begin
        src8             = '0;
        src8[NSRC-1:0]   = src_q;
    end

    assign vec_data  = ~ovr ? 16'h0000 :
                       cpu_address_in[1] ? ENTRY[15:0] : ENTRY[31:16];
    assign mir_data  = (sel_mir & mir_range) ? mir_rdata : 16'h0000;
    assign stat_data = (sel_mir & stat_hit)
                     ? status_word(src8, state_q) : 16'h0000;

    assign cart_data_out = vec_data | mir_data | stat_data;
    assign int7          = int7_q;
    assign frozen        = frozen_q;

endmodule

// File: tb/tb_freeze_cart_ctrl.sv
// Bench for freeze_cart_ctrl: behavioural model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_freeze_cart_ctrl;

    logic        clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        clk7_en = 1'b0;
    logic [23:1] cpu_address_in = '0;
    logic        _cpu_as = 1'b1;
    logic        cpu_rd = 1'b0;
    logic        cpu_hwr = 1'b0;
    logic        cpu_lwr = 1'b0;
    logic [31:0] cpu_vbr = '0;
    logic        dbr = 1'b0;
    logic        ovl = 1'b0;
    logic [7:0]  reg_address_in = '0;
    logic [15:0] reg_data_in = '0;
    logic        reg_wr = 1'b0;
    logic [1:0]  freeze = '0;
    logic [15:0] cart_data_out;
    logic        int7;
    logic        sel_cart;
    logic        ovr;
    logic        frozen;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    freeze_cart_ctrl dut (
        .clk            (clk),
        .cpu_rst        (cpu_rst),
        .clk7_en        (clk7_en),
        .cpu_address_in (cpu_address_in),
        ._cpu_as        (_cpu_as),
        .cpu_rd         (cpu_rd),
        .cpu_hwr        (cpu_hwr),
        .cpu_lwr        (cpu_lwr),
        .cpu_vbr        (cpu_vbr),
        .dbr            (dbr),
        .ovl            (ovl),
        .reg_address_in (reg_address_in),
        .reg_data_in    (reg_data_in),
        .reg_wr         (reg_wr),
        .freeze         (freeze),
        .cart_data_out  (cart_data_out),
        .int7           (int7),
        .sel_cart       (sel_cart),
        .ovr            (ovr),
        .frozen         (frozen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) clk7_en <= ~clk7_en;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 waiting for ack, 2 vector override, 3 monitor
    int          m_st = 0;
    logic [7:0]  m_src = '0;
    logic [1:0]  m_prev = '0;
    logic [31:0] m_nmi = 'x;
    logic [15:0] m_mem [256];
    logic [15:0] m_mrd = 'x;

    always @(posedge clk) begin : model
        logic [23:0] a;
        logic [1:0]  r;
        bit          fz;
        a = {cpu_address_in, 1'b0};
        m_mrd = m_mem[a[8:1]];
        if (clk7_en) begin
            fz = (m_st == 3);
            if (reg_wr && !fz) m_mem[reg_address_in] = reg_data_in;
            m_nmi = cpu_vbr + 32'h7C;
            if (cpu_rst) begin
                m_st = 0;
                m_src = '0;
                m_prev = '0;
            end else begin
                r = freeze & ~m_prev;
                m_prev = freeze;
                if (m_st == 0) begin
                    if (r != 0) begin
                        m_st = 1;
                        m_src = {6'b0, r};
                    end
                end else begin
                    m_src = m_src | {6'b0, r};
                    if (m_st == 1 && a == 24'hFFFFFE && !_cpu_as && cpu_rd)
                        m_st = 2;
                    else if (m_st == 2 && !dbr && a >= 24'hA00000 &&
                             a < 24'hA80000 && cpu_rd)
                        m_st = 3;
                    else if (m_st == 3 && !dbr && a == 24'hA9F202 &&
                             (cpu_hwr || cpu_lwr)) begin
                        m_st = 0;
                        m_src = '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [23:0] a;
        logic        e_ovr;
        logic [15:0] e_d;
        if (chk_on) begin
            a = {cpu_address_in, 1'b0};
            e_ovr = (m_st == 2) && !dbr && !ovl && cpu_rd &&
                    (a[23:2] == m_nmi[23:2]);
            e_d = '0;
            if (e_ovr) e_d = a[1] ? 16'h000C : 16'h00A1;
            if (!dbr && cpu_rd && a[23:12] == 12'hA9F) begin
                if (a[11:0] < 12'h200) e_d = e_d | m_mrd;
                else if (a[11:0] == 12'h200)
                    e_d = e_d | {m_src, 5'b0, 3'(m_st)};
            end
            chk("m_int7", int7, 32'(m_st == 1));
            chk("m_frozen", frozen, 32'(m_st == 3));
            chk("m_sel_cart", sel_cart,
                32'(!dbr && a >= 24'hA00000 && a < 24'hA80000));
            chk("m_ovr", ovr, 32'(e_ovr));
            if (!$isunknown(e_d)) chk("m_data", cart_data_out, 32'(e_d));
        end
    end

    task automatic tick7();
        bit en;
        do begin
            @(posedge clk);
            en = clk7_en;
        end while (!en);
        #1;
    endtask

    task automatic bus_idle();
        cpu_address_in = '0;
        cpu_rd = 1'b0;
        _cpu_as = 1'b1;
        cpu_hwr = 1'b0;
        cpu_lwr = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [23:0] a,
                          input logic [15:0] exp);
        cpu_address_in = a[23:1];
        cpu_rd = 1'b1;
        @(posedge clk);
        #1;
        chk(nm, cart_data_out, exp);
        bus_idle();
    endtask

    task automatic vec_chk(input string nm, input logic [23:0] a,
                           input logic [15:0] exp, input logic exp_ovr);
        cpu_address_in = a[23:1];
        cpu_rd = 1'b1;
        #2;
        chk({nm, "_d"}, cart_data_out, exp);
        chk({nm, "_ovr"}, ovr, exp_ovr);
        bus_idle();
    endtask

    task automatic reg_write(input logic [7:0] ra, input logic [15:0] d);
        reg_address_in = ra;
        reg_data_in = d;
        reg_wr = 1'b1;
        tick7();
        reg_wr = 1'b0;
    endtask

    task automatic ack_cycle();
        cpu_address_in = '1;
        _cpu_as = 1'b0;
        cpu_rd = 1'b1;
        tick7();
        bus_idle();
    endtask

    task automatic enter_monitor();
        cpu_address_in = 23'h50_0000;
        cpu_rd = 1'b1;
        tick7();
        bus_idle();
    endtask

    task automatic exit_write();
        cpu_address_in = 23'h54_F901;
        cpu_hwr = 1'b1;
        tick7();
        bus_idle();
    endtask

    task automatic pulse_freeze(input logic [1:0] f);
        freeze = f;
        tick7();
        freeze = '0;
    endtask

    initial begin
        tick7();
        tick7();
        cpu_rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_int7", int7, 0);
        chk("rst_frozen", frozen, 0);
        rd_chk("rst_status", 24'hA9F200, 16'h0000);

        reg_write(8'h80, 16'h1234);
        rd_chk("mir_1234", 24'hA9F100, 16'h1234);

        pulse_freeze(2'b01);
        chk("pend_int7", int7, 1);
        rd_chk("pend_status", 24'hA9F200, 16'h0101);
        ack_cycle();
        chk("ack_int7", int7, 0);
        rd_chk("ovr_status", 24'hA9F200, 16'h0102);

        vec_chk("vec_hi", 24'h00007C, 16'h00A1, 1'b1);
        vec_chk("vec_lo", 24'h00007E, 16'h000C, 1'b1);
        cpu_vbr = 32'h0001_0000;
        tick7();
        vec_chk("vbr_hi", 24'h01007C, 16'h00A1, 1'b1);
        vec_chk("vbr_lo", 24'h01007E, 16'h000C, 1'b1);
        vec_chk("old_vec", 24'h00007C, 16'h0000, 1'b0);
        ovl = 1'b1;
        vec_chk("ovl", 24'h01007C, 16'h0000, 1'b0);
        ovl = 1'b0;
        dbr = 1'b1;
        vec_chk("dbr", 24'h01007C, 16'h0000, 1'b0);
        dbr = 1'b0;

        enter_monitor();
        chk("act_frozen", frozen, 1);
        rd_chk("act_status", 24'hA9F200, 16'h0103);
        reg_write(8'h80, 16'hBEEF);
        rd_chk("mir_frozen", 24'hA9F100, 16'h1234);
        exit_write();
        chk("exit_frozen", frozen, 0);
        rd_chk("exit_status", 24'hA9F200, 16'h0000);
        rd_chk("exit_read", 24'hA9F202, 16'h0000);
        reg_write(8'h80, 16'hBEEF);
        rd_chk("mir_beef", 24'hA9F100, 16'hBEEF);

        pulse_freeze(2'b11);
        tick7();
        pulse_freeze(2'b10);
        rd_chk("src_pend", 24'hA9F200, 16'h0301);
        ack_cycle();
        enter_monitor();
        rd_chk("src_act", 24'hA9F200, 16'h0303);
        exit_write();
        rd_chk("src_exit", 24'hA9F200, 16'h0000);

        pulse_freeze(2'b01);
        chk("rp_int7_pre", int7, 1);
        cpu_rst = 1'b1;
        tick7();
        cpu_rst = 1'b0;
        chk("rp_int7", int7, 0);
        rd_chk("rp_status", 24'hA9F200, 16'h0000);

        pulse_freeze(2'b01);
        ack_cycle();
        cpu_address_in = 23'h00_803E;
        cpu_rd = 1'b1;
        #2;
        chk("ro_ovr_pre", ovr, 1);
        cpu_rst = 1'b1;
        tick7();
        cpu_rst = 1'b0;
        chk("ro_ovr", ovr, 0);
        chk("ro_int7", int7, 0);
        bus_idle();
        rd_chk("ro_status", 24'hA9F200, 16'h0000);

        cpu_rst = 1'b1;
        freeze = 2'b01;
        tick7();
        cpu_rst = 1'b0;
        freeze = '0;
        tick7();
        tick7();
        chk("rf_int7", int7, 0);
        rd_chk("rf_status", 24'hA9F200, 16'h0000);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
